// File: rtl/motor_pwm_ctrl_pkg.sv
// Shared definitions for the two-axis motor PWM controller.
package motor_pwm_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } pwm_state_t;

  localparam int DIR_BIT = 0;

  // Full 32-bit comparison so large requests saturate instead of wrapping.
  function automatic logic speed_saturates(input logic [31:0] speed, input int unsigned period);
    return speed >= period;
  endfunction

endpackage

// File: rtl/motor_pwm_channel.sv
// One motor axis: period/dead-time FSM with saturated duty and registered pwm/dir pins.
module motor_pwm_channel
  import motor_pwm_ctrl_pkg::*;
#(
  parameter int PERIOD      = 1000,
  parameter int CNT_W       = 10,
  parameter int DEAD_CYCLES = 50
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        enable,
  input  logic [31:0] speed,
  input  logic        direction_bit,
  output logic        pwm,
  output logic        dir,
  output logic        tick
);

  // One extra duty bit so a saturated duty of PERIOD fits even when PERIOD == 2**CNT_W.
  localparam int DUTY_W = CNT_W + 1;
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(PERIOD - 1);
  localparam logic [DUTY_W-1:0] FULL_DUTY = DUTY_W'(PERIOD);
  localparam logic [DEAD_W-1:0] LAST_DEAD = DEAD_W'(DEAD_CYCLES - 1);

  pwm_state_t        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DUTY_W-1:0] duty_reg;
  logic [DUTY_W-1:0] pend_duty_reg;
  logic [DUTY_W-1:0] duty_next;
  logic [DEAD_W-1:0] dead_reg;
  logic              dir_reg;
  logic              pend_dir_reg;
  logic              pwm_reg;

  always_comb begin
    duty_next = speed_saturates(speed, PERIOD) ? FULL_DUTY : {1'b0, speed[CNT_W-1:0]};
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      duty_reg      <= '0;
      pend_duty_reg <= '0;
      dead_reg      <= '0;
      dir_reg       <= 1'b0;
      pend_dir_reg  <= 1'b0;
      pwm_reg       <= 1'b0;
    end else begin
      pwm_reg <= (state_reg == RUN) && ({1'b0, cnt_reg} < duty_reg);
      if (!enable) begin
        state_reg <= IDLE;
        cnt_reg   <= '0;
        dead_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            duty_reg  <= duty_next;
            dir_reg   <= direction_bit;
            cnt_reg   <= '0;
            state_reg <= RUN;
          end
          RUN: begin
            if (cnt_reg == LAST_CNT) begin
              cnt_reg <= '0;
              if (direction_bit == dir_reg) begin
                duty_reg <= duty_next;
              end else begin
                pend_dir_reg  <= direction_bit;
                pend_duty_reg <= duty_next;
                dead_reg      <= '0;
                state_reg     <= DEAD;
              end
            end else begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
          end
          DEAD: begin
            // Direction pin only flips once the bridge has been off for the full dead time.
            if (dead_reg == LAST_DEAD) begin
              dir_reg   <= pend_dir_reg;
              duty_reg  <= pend_duty_reg;
              cnt_reg   <= '0;
              dead_reg  <= '0;
              state_reg <= RUN;
            end else begin
              dead_reg <= dead_reg + DEAD_W'(1);
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign pwm  = pwm_reg;
  assign dir  = dir_reg;
  assign tick = (state_reg == RUN) && (cnt_reg == LAST_CNT);

endmodule

// File: rtl/motor_pwm_ctrl.sv
// Two independent motor PWM channels (X, Y) fed by the motion registers.
module motor_pwm_ctrl
  import motor_pwm_ctrl_pkg::*;
#(
  parameter int PERIOD      = 1000,
  parameter int CNT_W       = 10,
  parameter int DEAD_CYCLES = 50
) (
  input  logic        clock,
  input  logic        ctrl_reset_n,
  input  logic        enable,
  input  logic [31:0] xSpeed,
  input  logic [31:0] xDirection,
  input  logic [31:0] ySpeed,
  input  logic [31:0] yDirection,
  output logic        pwm_x,
  output logic        dir_x,
  output logic        pwm_y,
  output logic        dir_y,
  output logic        period_tick
);

  // Index 0 is the X axis, index 1 the Y axis.
  logic [31:0] speed_arr [2];
  logic        dir_bit_arr [2];
  logic        pwm_arr [2];
  logic        dir_arr [2];
  logic        tick_arr [2];
  logic        unused_ok;

  assign speed_arr[0]   = xSpeed;
  assign speed_arr[1]   = ySpeed;
  assign dir_bit_arr[0] = xDirection[DIR_BIT];
  assign dir_bit_arr[1] = yDirection[DIR_BIT];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      motor_pwm_channel #(
        .PERIOD      (PERIOD),
        .CNT_W       (CNT_W),
        .DEAD_CYCLES (DEAD_CYCLES)
      ) u_channel (
        .clock         (clock),
        .ctrl_reset_n  (ctrl_reset_n),
        .enable        (enable),
        .speed         (speed_arr[gi]),
        .direction_bit (dir_bit_arr[gi]),
        .pwm           (pwm_arr[gi]),
        .dir           (dir_arr[gi]),
        .tick          (tick_arr[gi])
      );
    end
  endgenerate

  assign pwm_x       = pwm_arr[0];
  assign dir_x       = dir_arr[0];
  assign pwm_y       = pwm_arr[1];
  assign dir_y       = dir_arr[1];
  assign period_tick = tick_arr[0];

  assign unused_ok = ^{tick_arr[1], xDirection[31:1], yDirection[31:1]};

endmodule

// File: doc/motor_pwm_ctrl.md
Name: motor_pwm_ctrl

Overview:
- Converts the processor-written motion words (ySpeed, yDirection, xSpeed, xDirection) into PWM and direction pins for two DC motor drivers (X and Y axes).
- Sits directly downstream of the register file, fed from its motion-register outputs, and drives the FPGA pins to the H-bridges.
- New speed and direction values are applied only at PWM period boundaries.
- Every direction reversal inserts a dead-time interval with PWM forced low.

Parameters:
- PERIOD, 1000: PWM period in clock cycles. Must be ≥2.
- CNT_W, 10: width of the period and duty counters. Must satisfy 2^CNT_W ≥ PERIOD.
- DEAD_CYCLES, 50: cycles of forced-low PWM before the direction pin flips. Must be ≥1.

Ports:
- clock  in  1  system clock.
- ctrl_reset_n  in  1  reset, synchronous, active-low.
- enable  in  1  master motor enable (switch-driven).
- xSpeed  in  32  X duty request, unsigned, in clock cycles high per period.
- xDirection  in  32  X direction; bit0 only (1 = reverse).
- ySpeed  in  32  Y duty request, same encoding as xSpeed.
- yDirection  in  32  Y direction; bit0 only.
- pwm_x  out  1  X PWM pin.
- dir_x  out  1  X direction pin.
- pwm_y  out  1  Y PWM pin.
- dir_y  out  1  Y direction pin.
- period_tick  out  1  one-cycle pulse on X channel cnt==PERIOD-1. Used as a debug/strobe.

Behaviour:
- Reset (ctrl_reset_n==0 at a clock edge): both channels go to IDLE with cnt=0, duty=0, dir=0, dead=0. All outputs are 0 from the following cycle. Reset mid-period or mid-dead-time aborts immediately and no pending direction is applied.
- Duty saturation: duty_next = (speed ≥ PERIOD) ? PERIOD : speed[CNT_W-1:0]. The comparison uses all 32 bits.
  - speed=0 gives constant low.
  - speed ≥ PERIOD gives constant high.
- pwm = (state==RUN) && (cnt < duty). It is registered, so the pin reflects the state/cnt of the previous cycle (1-cycle latency).
- dir pin is the registered dir_q.
- Per-channel FSM:
  - IDLE: cnt=0, pwm=0. When enable==1, load duty from duty_next and dir_q from direction[0], then go to RUN with cnt=0. No dead time is inserted from IDLE.
  - RUN: cnt increments each cycle. At cnt==PERIOD-1 (boundary), sample the inputs:
    - If direction[0]==dir_q: load duty, set cnt to 0, stay in RUN.
    - If direction[0]!=dir_q: latch pend_dir and pend_duty, go to DEAD with dead=0.
  - DEAD: pwm=0 and dir unchanged. dead increments; at dead==DEAD_CYCLES-1, set dir_q←pend_dir, duty←pend_duty, cnt←0, and go to RUN. Input changes during DEAD are ignored until the next boundary.
- enable==0 in any state forces IDLE on the next edge, including mid-DEAD; a pending direction is discarded. enable has priority over a boundary on the same edge.
- Input changes mid-period have no effect until the boundary. A speed change and a direction change at the same boundary take the DEAD path, and the new duty is applied after DEAD.
- The X and Y channels are fully independent. Their counters are aligned only when enable rises simultaneously.
- period_tick is 0 when the X channel is not in RUN.

Decomposition:
- Shared package/header holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DEAD=2'd2;
  - bit index constant DIR_BIT=0.
- Natural sub-module: motor_pwm_channel (one axis: FSM, counters, saturation, registered pwm/dir). It is instantiated twice by motor_pwm_ctrl, which only wires the channels and derives period_tick.

Test Plan (all with PERIOD=8, DEAD_CYCLES=3):
- Reset held for 3 cycles, then enable=1 with xSpeed=3 and xDirection=0 → pwm_x repeats 1,1,1,0,0,0,0,0 starting 1 cycle after enable; dir_x=0; period_tick every 8 cycles.
- xSpeed=0 → pwm_x constantly 0. xSpeed=8 and xSpeed=32'hFFFF_0000 → pwm_x constantly 1 (saturation).
- Running with xSpeed=4, change xSpeed to 6 at cnt=2 → remainder of the current period keeps 4 high; the next period has 6 high.
- Running with dir 0, set xDirection=1 and xSpeed=5 → at the boundary pwm_x is low for 3 cycles with dir_x still 0. dir_x then goes to 1 and the pattern becomes 5-high/3-low.
- Drop enable during DEAD → pwm_x=0 and dir_x stays 0. On re-enable, dir_x=1 appears immediately with no dead time.
- Assert ctrl_reset_n=0 mid-period with different X and Y speeds → all outputs are 0 next cycle. After release with enable still 1, both channels restart from cnt=0 in lockstep.
